// File: rtl/clk_enable_gen.sv
// clk_enable_gen
//   Multi-channel fractional clock-enable generator running on one PLL output clock.
//   Each channel owns an ACC_W-bit phase accumulator. Its increment is added every cycle while
//   the lock FSM is in RUN. The carry out of that add becomes a single-cycle ce pulse one edge
//   later, so the pulse rate is f_refclk * INC / 2^ACC_W.
//   Increments can be reprogrammed at runtime. A new value is parked in a pending register and
//   only takes over at the channel's next carry, so no pulse interval is shortened or doubled.
//
// Ports
//   refclk      in   system clock; all state changes on its rising edge
//   rst_n       in   asynchronous active-low reset
//   pll_locked  in   asynchronous PLL lock, double-flop synchronised here
//   cfg_wr      in   one-cycle increment write strobe
//   cfg_ch      in   target channel of the write; values >= NUM_CH are ignored
//   cfg_inc     in   new increment
//   align       in   (CLK_ENABLE_GEN_ALIGN_EN only) zero all accumulators in RUN
//   ready       out  lock has been stable long enough; generators running
//   ce          out  per-channel single-cycle enable pulses
//
// Optional feature macro: CLK_ENABLE_GEN_ALIGN_EN adds the align input and its logic.

module clk_enable_gen #(
    parameter int unsigned NUM_CH    = 3,
    parameter int unsigned ACC_W     = 16,
    parameter int unsigned LOCK_WAIT = 1024,
    parameter logic [NUM_CH*ACC_W-1:0] INC_INIT = '0,
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
`ifdef CLK_ENABLE_GEN_ALIGN_EN
    input  logic              align,
`endif
    output logic              ready,
    output logic [NUM_CH-1:0] ce
);

    localparam int unsigned CNT_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_WAIT - 1);

    typedef enum logic [1:0] {
        StWaitLock,
        StStable,
        StRun
    } lock_state_e;

    lock_state_e      state_q;
    logic [CNT_W-1:0] lock_cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [1:0]       sync_q;
    logic             lk;
    logic             hold;
    logic             run_add;
    logic             cfg_valid;

    // Two-flop synchroniser for the asynchronous lock input.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    assign lk = sync_q[1];

    // Saturating increment; the FSM leaves STABLE before it would wrap.
    assign cnt_inc = (lock_cnt_q == CNT_LAST) ? lock_cnt_q : lock_cnt_q + 1'b1;

    // Lock FSM. ready is registered and is high exactly while in RUN.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StWaitLock;
            lock_cnt_q <= '0;
            ready      <= 1'b0;
        end else begin
            case (state_q)
                StWaitLock: begin
                    lock_cnt_q <= '0;
                    if (lk) begin
                        // The cycle that leaves WAIT_LOCK is the first locked cycle.
                        if (LOCK_WAIT == 1) begin
                            state_q <= StRun;
                            ready   <= 1'b1;
                        end else begin
                            state_q <= StStable;
                        end
                    end
                end
                StStable: begin
                    if (!lk) begin
                        state_q    <= StWaitLock;
                        lock_cnt_q <= '0;
                    end else begin
                        lock_cnt_q <= cnt_inc;
                        if (cnt_inc == CNT_LAST) begin
                            state_q <= StRun;
                            ready   <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (!lk) begin
                        state_q    <= StWaitLock;
                        lock_cnt_q <= '0;
                        ready      <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= StWaitLock;
                    lock_cnt_q <= '0;
                    ready      <= 1'b0;
                end
            endcase
        end
    end

`ifdef CLK_ENABLE_GEN_ALIGN_EN
    assign hold = ready & align;
`else
    assign hold = 1'b0;
`endif

    // Accumulators advance only while running and still locked; on the lock-loss edge they clear.
    assign run_add   = ready & lk & ~hold;
    assign cfg_valid = (32'(cfg_ch) < NUM_CH);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [ACC_W-1:0] acc_q;
        logic [ACC_W-1:0] active_inc_q;
        logic [ACC_W-1:0] pending_q;
        logic             pending_valid_q;
        logic             ce_q;
        logic [ACC_W:0]   sum;
        logic             carry;
        logic             wr_hit;
        logic             idle_commit;

        assign sum    = {1'b0, acc_q} + {1'b0, active_inc_q};
        assign carry  = run_add & sum[ACC_W];
        assign wr_hit = cfg_wr & cfg_valid & (cfg_ch == CH_W'(i));
        // No carry can ever arrive to act as the commit point, so commit straight away.
        assign idle_commit = ~hold & (~ready | (active_inc_q == '0));

        always_ff @(posedge refclk or negedge rst_n) begin
            if (!rst_n) begin
                acc_q           <= '0;
                active_inc_q    <= INC_INIT[i*ACC_W +: ACC_W];
                pending_q       <= '0;
                pending_valid_q <= 1'b0;
                ce_q            <= 1'b0;
            end else begin
                acc_q <= run_add ? sum[ACC_W-1:0] : '0;
                ce_q  <= carry;
                if (carry) begin
                    // Pulse boundary: a same-cycle write beats any older pending value.
                    if (wr_hit) begin
                        active_inc_q <= cfg_inc;
                    end else if (pending_valid_q) begin
                        active_inc_q <= pending_q;
                    end
                    pending_valid_q <= 1'b0;
                end else if (wr_hit) begin
                    pending_q       <= cfg_inc;
                    pending_valid_q <= 1'b1;
                end else if (pending_valid_q && idle_commit) begin
                    active_inc_q    <= pending_q;
                    pending_valid_q <= 1'b0;
                end
            end
        end

        assign ce[i] = ce_q;
    end

endmodule

// File: doc/clk_enable_gen.md
Name: clk_enable_gen

Overview:
- Multi-channel fractional clock-enable generator, driven by one PLL output clock.
- Replaces extra PLL outputs for slow or odd rates: each channel emits single-cycle enable pulses at f_refclk*INC/2^ACC_W.
- Gated by PLL lock with a stability wait. Per-channel rate is reprogrammable at runtime without glitches.

Parameters:
- NUM_CH, 3, number of enable channels (1..16).
- ACC_W, 16, phase accumulator / increment width (8..32).
- LOCK_WAIT, 1024, consecutive synchronised-locked cycles required before ready (>=1).
- INC_INIT, {NUM_CH{16'h0000}}, flat NUM_CH*ACC_W reset increments; channel i at bits [i*ACC_W +: ACC_W].
- Localparam CH_W = max(1, clog2(NUM_CH)).

Ports:
- refclk  in  1  system clock (PLL output); all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL lock, asynchronous; double-flop synchronised internally.
- cfg_wr  in  1  increment write strobe, one cycle.
- cfg_ch  in  CH_W  target channel; values >= NUM_CH ignored.
- cfg_inc  in  ACC_W  new increment.
- ready  out  1  lock stable, generators running.
- ce  out  NUM_CH  per-channel enable pulses, one cycle each.

Behaviour:
- Reset (async assert, sync release on refclk) sets:
  - ce=0, ready=0.
  - All accumulators = 0; active_inc[i] = INC_INIT[i]; all pending_valid = 0.
  - Lock counter = 0; synchroniser flops = 0.
- Lock FSM states: WAIT_LOCK, STABLE, RUN. lk denotes synchronised pll_locked (2-cycle latency).
  - WAIT_LOCK: counter = 0. Go to STABLE when lk = 1.
  - STABLE: counter increments each cycle. On lk = 0, return to WAIT_LOCK. Go to RUN when counter reaches LOCK_WAIT-1 with lk = 1. The counter saturates and never wraps.
  - RUN: ready = 1 (registered). On lk = 0: ready = 0, all accumulators cleared and all ce = 0 on the next edge, return to WAIT_LOCK.
- Lock loss leaves active_inc and pending registers intact.
- Accumulator, per channel, only in RUN:
  - Update: {carry, acc} <= acc + active_inc (ACC_W+1 bit sum), applied every cycle.
  - ce[i] <= carry, registered.
  - Timing: if R is the first cycle with ready = 1, the first add occurs at the end of R.
  - Example: INC = 2^(ACC_W-1) gives ce high in R+2, R+4, and so on.
  - Corner values: INC = 0 never pulses. INC = 2^ACC_W-1 pulses on all but one cycle in every 2^ACC_W.
- Runtime update:
  - A cfg_wr to a valid channel loads pending[ch] and sets pending_valid[ch]. A later write before commit overwrites the pending value (last write wins).
  - Commit: active_inc <= pending and pending_valid cleared, on the edge where that channel's carry = 1. This makes the rate change at a pulse boundary and stops any pulse being shortened or doubled.
  - Write in the same cycle as that channel's carry: cfg_inc goes straight into active_inc and pending_valid clears; the older pending value is discarded.
  - Commit happens immediately (next edge) when ready = 0 or active_inc = 0, because no carry would ever occur.
- All channels are independent. Simultaneous carries on several channels are legal.

Optional Feature:
- Macro: CLK_ENABLE_GEN_ALIGN_EN.
- Defined: adds input port align (1 bit), sampled only in RUN. When align = 1, every accumulator loads 0 and every ce = 0 on the next edge; pending commits in that cycle are deferred. Gives a common phase reference across channels, e.g. video/audio restart.
- Undefined: no align port, and no align logic is synthesised.

Test Plan:
- Reset with rst_n = 0 mid-run -> ce = 0, ready = 0 immediately (async); INC_INIT restored; lock FSM back in WAIT_LOCK.
- LOCK_WAIT = 16, pll_locked rises -> ready high exactly 2+16 cycles later. A 1-cycle low glitch at count 10 -> count restarts, ready delayed accordingly.
- ACC_W = 16 with increments 0x8000, 0x4000, 0x5556 -> pulses every 2 and every 4 cycles; 0x5556 gives 21846 pulses per 65536 cycles, spacing 2–3 cycles. INC = 0 -> ce stays 0 for 1000 cycles.
- Write 0x4000 to ch0 while active 0x2000 with acc mid-period -> old spacing 8 holds until the next ce, then spacing becomes 4 with no short interval. Write coinciding with carry -> the new value is active from that edge. Write with cfg_ch = 3 when NUM_CH = 3 -> no effect.
- Drop pll_locked in RUN -> after 2-cycle sync, ready = 0 and ce = 0 the next cycle. Re-lock -> restart after LOCK_WAIT with accumulators at 0 and increments retained.
- With CLK_ENABLE_GEN_ALIGN_EN: channels at 0x4000 and 0x3000 drifting, pulse align -> both first ce land at the expected offsets after align (4 and 6 cycles).
